instr_encoder_loader: RTL

- Inverse of the control-unit instruction decoder. Accepts field-level instruction requests (op, funct, rn, rd, imm) over a valid/ready handshake.
- Assembles each request into a 32-bit ARM machine word with a fixed condition field.
- Buffers encoded words in a small FIFO, then streams them into instruction memory at consecutive word addresses.
- Used as the bench/boot-time program loader in front of imem.

---
 rtl/instr_encoder_loader.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/instr_encoder_loader.sv
// Field-level instruction encoder and imem program loader: encodes requests into
// ARM words, buffers them in a FIFO and streams them to consecutive imem addresses.
module instr_encoder_loader #(
  parameter int unsigned DEPTH = 4,
  parameter logic [3:0]  COND  = 4'hE
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [31:0] base_addr,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic        in_last,
  input  logic [1:0]  op,
  input  logic [5:0]  funct,
  input  logic [3:0]  rn,
  input  logic [3:0]  rd,
  input  logic [23:0] imm,
  output logic        mem_we,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wd,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [7:0]  wcount
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

  typedef enum logic [1:0] {IDLE, LOAD, FLUSH, DONE} state_t;

  state_t        state, state_nxt;
  logic [31:0]   fifo_mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0]   count;
  logic          fifo_full, fifo_empty;
  logic          accept, illegal, push, pop;
  logic [31:0]   enc_word;
  logic [31:0]   next_addr;

  assign fifo_full  = (count == FULL_CNT);
  assign fifo_empty = (count == '0);
  assign illegal    = (op == 2'b11);
  assign accept     = in_valid && in_ready;
  assign push       = accept && !illegal;
  // The stage refills whenever it is empty or its current write retires this cycle.
  assign pop        = !fifo_empty && (!mem_we || mem_ready);

  always_comb begin
    enc_word = '0;
    case (op)
      2'b00, 2'b01: enc_word = {COND, op, funct, rn, rd, imm[11:0]};
      2'b10:        enc_word = {COND, 2'b10, funct[5:4], imm};
      default:      enc_word = '0;
    endcase
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      IDLE: begin
        if (start) state_nxt = LOAD;
      end
      LOAD: begin
        busy     = 1'b1;
        in_ready = !fifo_full;
        if (in_valid && !fifo_full && in_last) state_nxt = FLUSH;
      end
      FLUSH: begin
        busy = 1'b1;
        if (fifo_empty && !mem_we) state_nxt = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (push) fifo_mem[wr_ptr] <= enc_word;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wd    <= '0;
      next_addr <= '0;
    end else begin
      if (state == IDLE && start) next_addr <= base_addr;
      if (pop) begin
        mem_we    <= 1'b1;
        mem_addr  <= next_addr;
        mem_wd    <= fifo_mem[rd_ptr];
        next_addr <= next_addr + 32'd4;
      end else if (mem_we && mem_ready) begin
        mem_we <= 1'b0;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      err    <= 1'b0;
      wcount <= '0;
    end else if (state == IDLE && start) begin
      err    <= 1'b0;
      wcount <= '0;
    end else begin
      if (accept && illegal) err <= 1'b1;
      if (mem_we && mem_ready && wcount != 8'hFF) wcount <= wcount + 8'd1;
    end
  end

endmodule
